// File: rtl/ctc_rom_seq_if.sv
// Bus between the ROM address sequencer and its surroundings: word-time state,
// serial ROM link, carry/keycode inputs and observed address state.
interface ctc_rom_seq_if #(
   parameter int ADR_W = 8
);
   logic [5:0]       sys_cnt;
   logic             is;
   logic             carry;
   logic [5:0]       kcode;
   logic             ia;
   logic [ADR_W-1:0] adr;
   logic [ADR_W-1:0] rtn_adr;
   logic             brh_taken;

   modport master (
      output sys_cnt, is, carry, kcode,
      input  ia, adr, rtn_adr, brh_taken
   );

   modport slave (
      input  sys_cnt, is, carry, kcode,
      output ia, adr, rtn_adr, brh_taken
   );
endinterface

// File: rtl/ctc_rom_seq.sv
// Bit-serial ROM address sequencer: shifts the address out, captures the serial
// instruction, and resolves the next program address once per 56-state word.
module ctc_rom_seq #(
   parameter int         ADR_W     = 8,
   parameter int         IA_START  = 19,
   parameter int         IS_START  = 45,
   parameter int         WORD_LAST = 55,
   parameter logic [9:0] RTN_OP    = 10'h030,
   parameter logic [9:0] KEY_OP    = 10'h0D0
) (
   input logic           cph2,
   input logic           pon,
   ctc_rom_seq_if.slave  bus
);

   localparam logic [5:0] IS_FIRST = 6'(IS_START);
   localparam logic [5:0] IS_LAST  = 6'(IS_START + 9);
   localparam logic [5:0] T_LAST   = 6'(WORD_LAST);
   localparam logic [3:0] BITS_ALL = 4'd10;

   logic [ADR_W-1:0] adr_q, adr_d;
   logic [ADR_W-1:0] rtn_adr_q, rtn_adr_d;
   logic [9:0]       inst_sr_q, inst_sr_d;
   logic [3:0]       bcnt_q, bcnt_d;
   logic             inst_ok_q, inst_ok_d;
   logic             carry_acc_q, carry_acc_d;
   logic             brh_taken_q, brh_taken_d;

   logic [ADR_W-1:0] adr_inc;
   logic [ADR_W-1:0] ia_hit;
   logic             in_word;
   logic             is_cap;
   logic             at_last;

   // Serial address: one slot per address bit, LSB first; any other state reads 0.
   genvar gi;
   generate
      for (gi = 0; gi < ADR_W; gi++) begin : g_ia
         localparam logic [5:0] SLOT = 6'(IA_START + gi);
         assign ia_hit[gi] = (bus.sys_cnt == SLOT) & adr_q[gi];
      end
   endgenerate

   assign bus.ia = |ia_hit;

   assign in_word = (bus.sys_cnt <= T_LAST);
   assign is_cap  = (bus.sys_cnt >= IS_FIRST) && (bus.sys_cnt <= IS_LAST);
   assign at_last = (bus.sys_cnt == T_LAST);
   assign adr_inc = adr_q + ADR_W'(1);

   always_comb begin
      adr_d       = adr_q;
      rtn_adr_d   = rtn_adr_q;
      inst_sr_d   = inst_sr_q;
      bcnt_d      = bcnt_q;
      inst_ok_d   = inst_ok_q;
      carry_acc_d = carry_acc_q;
      brh_taken_d = 1'b0;

      if (is_cap) begin
         inst_sr_d = {bus.is, inst_sr_q[9:1]};
         if (bcnt_q != BITS_ALL) begin
            bcnt_d = bcnt_q + 4'd1;
         end
         if (bcnt_q == BITS_ALL - 4'd1) begin
            inst_ok_d = 1'b1;
         end
      end

      // Carry in the decision state itself is deliberately not folded in.
      if (in_word && !at_last) begin
         carry_acc_d = carry_acc_q | bus.carry;
      end

      if (at_last) begin
         bcnt_d      = 4'd0;
         inst_ok_d   = 1'b0;
         carry_acc_d = 1'b0;

         if (!inst_ok_q) begin
            adr_d = adr_inc;
         end else if (inst_sr_q == RTN_OP) begin
            adr_d = rtn_adr_q;
         end else if (inst_sr_q == KEY_OP) begin
            adr_d       = ADR_W'(bus.kcode);
            brh_taken_d = 1'b1;
         end else if (inst_sr_q[1:0] == 2'b01) begin
            rtn_adr_d   = adr_inc;
            adr_d       = ADR_W'(inst_sr_q[9:2]);
            brh_taken_d = 1'b1;
         end else if (inst_sr_q[1:0] == 2'b11) begin
            if (!carry_acc_q) begin
               adr_d       = ADR_W'(inst_sr_q[9:2]);
               brh_taken_d = 1'b1;
            end else begin
               adr_d = adr_inc;
            end
         end else begin
            adr_d = adr_inc;
         end
      end
   end

   always_ff @(posedge cph2 or posedge pon) begin
      if (pon) begin
         adr_q       <= '0;
         rtn_adr_q   <= '0;
         inst_sr_q   <= '0;
         bcnt_q      <= '0;
         inst_ok_q   <= 1'b0;
         carry_acc_q <= 1'b0;
         brh_taken_q <= 1'b0;
      end else begin
         adr_q       <= adr_d;
         rtn_adr_q   <= rtn_adr_d;
         inst_sr_q   <= inst_sr_d;
         bcnt_q      <= bcnt_d;
         inst_ok_q   <= inst_ok_d;
         carry_acc_q <= carry_acc_d;
         brh_taken_q <= brh_taken_d;
      end
   end

   assign bus.adr       = adr_q;
   assign bus.rtn_adr   = rtn_adr_q;
   assign bus.brh_taken = brh_taken_q;

endmodule

// File: tb/tb_ctc_rom_seq.sv
// Directed bench for ctc_rom_seq: drives whole word times and checks the
// address flow against hand-computed results.
module tb_ctc_rom_seq;

   logic cph2 = 1'b0;
   logic pon  = 1'b1;

   ctc_rom_seq_if #(.ADR_W(8)) bus ();

   ctc_rom_seq dut (
      .cph2 (cph2),
      .pon  (pon),
      .bus  (bus.slave)
   );

   always #5 cph2 = ~cph2;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] ia_cap;
   int         brh_in_word;
   logic [7:0] pon_adr, pon_rtn;
   logic       pon_ia;
   logic       ill_ia;
   int         ill_adr_chg;
   int         ill_rtn_chg;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s : got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s : %0h", tag, got);
      end
   endtask

   // One word time. kcode carries kc only during T55; pon_at/ill_at < 0 disable those events.
   task automatic run_word(input logic [9:0] inst, input int carry_at, input logic [5:0] kc,
                           input int pon_at, input int ill_at);
      logic [7:0] a0, r0;
      ia_cap      = '0;
      brh_in_word = 0;
      ill_ia      = 1'b0;
      ill_adr_chg = 0;
      ill_rtn_chg = 0;
      for (int s = 0; s < 56; s++) begin
         if (s == ill_at) begin
            a0 = bus.adr;
            r0 = bus.rtn_adr;
            for (int k = 0; k < 4; k++) begin
               bus.sys_cnt = 6'd60;
               bus.is      = 1'b1;
               bus.carry   = 1'b1;
               #1;
               ill_ia = ill_ia | bus.ia;
               @(posedge cph2); #1;
               if (bus.adr !== a0) ill_adr_chg++;
               if (bus.rtn_adr !== r0) ill_rtn_chg++;
            end
         end
         bus.sys_cnt = 6'(s);
         bus.is      = (s >= 45 && s <= 54) ? inst[s-45] : 1'b0;
         bus.carry   = (s == carry_at);
         bus.kcode   = (s == 55) ? kc : 6'h15;
         if (s == pon_at) pon = 1'b1;
         if (s == pon_at + 1) pon = 1'b0;
         #1;
         if (s == pon_at) begin
            pon_adr = bus.adr;
            pon_rtn = bus.rtn_adr;
            pon_ia  = bus.ia;
         end
         if (s >= 19 && s <= 26) ia_cap[s-19] = bus.ia;
         if (s > 0 && bus.brh_taken) brh_in_word++;
         @(posedge cph2); #1;
      end
   endtask

   task automatic word_end(input string tag, input logic [7:0] exp_adr, input logic [7:0] exp_rtn,
                           input logic exp_brh);
      check_val({tag, " adr"}, 32'(bus.adr), 32'(exp_adr));
      check_val({tag, " rtn_adr"}, 32'(bus.rtn_adr), 32'(exp_rtn));
      check_val({tag, " brh_taken"}, 32'(bus.brh_taken), 32'(exp_brh));
      check_val({tag, " brh idle in word"}, 32'(brh_in_word), 32'd0);
   endtask

   initial begin
      bus.sys_cnt = 6'd19;
      bus.is      = 1'b0;
      bus.carry   = 1'b0;
      bus.kcode   = 6'h00;
      repeat (3) @(posedge cph2);
      #1;
      check_val("reset adr", 32'(bus.adr), 32'h00);
      check_val("reset rtn_adr", 32'(bus.rtn_adr), 32'h00);
      check_val("reset brh_taken", 32'(bus.brh_taken), 32'h0);
      check_val("reset ia", 32'(bus.ia), 32'h0);
      pon = 1'b0;

      run_word(10'h000, -1, 6'h00, -1, -1);
      word_end("nop w0", 8'h01, 8'h00, 1'b0);
      run_word(10'h000, -1, 6'h00, -1, -1);
      word_end("nop w1", 8'h02, 8'h00, 1'b0);
      run_word(10'h000, -1, 6'h00, -1, -1);
      check_val("ia serial adr 02", 32'(ia_cap), 32'h02);
      word_end("nop w2", 8'h03, 8'h00, 1'b0);

      run_word(10'h041, -1, 6'h00, -1, -1);
      word_end("jsb to 10", 8'h10, 8'h04, 1'b1);
      run_word(10'h0A5, -1, 6'h00, -1, -1);
      word_end("jsb to 29", 8'h29, 8'h11, 1'b1);
      run_word(10'h030, -1, 6'h00, -1, -1);
      check_val("ia serial adr 29", 32'(ia_cap), 32'h29);
      word_end("return", 8'h11, 8'h11, 1'b0);

      run_word(10'h0C3, 12, 6'h00, -1, -1);
      word_end("branch carry T12", 8'h12, 8'h11, 1'b0);
      run_word(10'h0C3, 55, 6'h00, -1, -1);
      word_end("branch carry T55", 8'h30, 8'h11, 1'b1);

      run_word(10'h0D0, -1, 6'h2A, -1, -1);
      word_end("keycode jump", 8'h2A, 8'h11, 1'b1);

      run_word(10'h3FD, -1, 6'h00, -1, -1);
      word_end("jsb to FF", 8'hFF, 8'h2B, 1'b1);
      run_word(10'h101, -1, 6'h00, -1, -1);
      word_end("jsb at FF", 8'h40, 8'h00, 1'b1);
      run_word(10'h3FD, -1, 6'h00, -1, -1);
      word_end("jsb to FF again", 8'hFF, 8'h41, 1'b1);
      run_word(10'h000, -1, 6'h00, -1, -1);
      word_end("nop wrap", 8'h00, 8'h41, 1'b0);
      run_word(10'h3FE, -1, 6'h00, -1, -1);
      word_end("class 10 inc", 8'h01, 8'h41, 1'b0);
      run_word(10'h155, -1, 6'h00, -1, -1);
      word_end("jsb to 55", 8'h55, 8'h02, 1'b1);

      run_word(10'h0A5, -1, 6'h00, 50, -1);
      check_val("pon mid-word adr", 32'(pon_adr), 32'h00);
      check_val("pon mid-word rtn_adr", 32'(pon_rtn), 32'h00);
      check_val("pon mid-word ia", 32'(pon_ia), 32'h0);
      word_end("partial capture nop", 8'h01, 8'h00, 1'b0);

      run_word(10'h0C3, -1, 6'h00, -1, 47);
      check_val("illegal cnt ia", 32'(ill_ia), 32'h0);
      check_val("illegal cnt adr held", 32'(ill_adr_chg), 32'd0);
      check_val("illegal cnt rtn held", 32'(ill_rtn_chg), 32'd0);
      word_end("branch after illegal", 8'h30, 8'h00, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog : got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ctc_rom_seq.md
Name: ctc_rom_seq

Overview:
- Bit-serial ROM address sequencer for the control & timing chip.
- Once per 56-state word time, it:
  - shifts the current ROM address out on ia;
  - captures the 10-bit instruction returned serially on is;
  - decodes the instruction's flow-control class;
  - computes the next address (increment, subroutine jump, return, conditional branch or keycode jump).
- It sits between the system word counter / carry line and the external ROM, and is the single owner of the program address and return address.

Parameters:
- ADR_W, 8, ROM address width.
- IA_START, 19, first word state in which ia carries address bit 0.
- IS_START, 45, first word state in which is carries instruction bit 0.
- WORD_LAST, 55, last state of the word counter.
- RTN_OP, 10'h030, instruction code for subroutine return.
- KEY_OP, 10'h0D0, instruction code for keycode jump.

Ports:
- cph2  input  1  system clock; all state updates on rising edge.
- pon  input  1  power-on reset, asynchronous, active-high.
- sys_cnt  input  6  word-time state from the timing generator, 0..55.
- is  input  1  serial instruction bit from ROM, LSB first.
- carry  input  1  arithmetic carry from the datapath.
- kcode  input  6  latched keycode from the key scanner.
- ia  output  1  serial ROM address, LSB first.
- adr  output  ADR_W  current ROM address (debug/observe).
- rtn_adr  output  ADR_W  return address register.
- brh_taken  output  1  one-cycle pulse at T55 when a branch or jump redirects flow.

Behaviour:
- Reset (pon=1, async): adr=0, rtn_adr=0, instruction shift register=0, bit count=0, inst_ok=0, carry_acc=0, ia=0, brh_taken=0. Outputs hold these values while pon is asserted.
- ia is combinational from registered state:
  - ia = adr[sys_cnt-IA_START] for sys_cnt in IA_START..IA_START+ADR_W-1;
  - ia = 0 in all other states.
- Instruction capture:
  - For sys_cnt in IS_START..IS_START+9: inst_sr <= {is, inst_sr[9:1]} and bit count increments.
  - inst_ok=1 only if all 10 capture states occurred since the last T55 or reset.
  - A partial capture, e.g. pon released at T50, sets inst_ok=0.
- Carry accumulation:
  - carry_acc <= carry_acc | carry for sys_cnt 0..54.
  - At T55, carry_acc is used for the branch decision and then cleared to 0 in the same edge.
- Next-address decision: made at the edge where sys_cnt==WORD_LAST. Priority order:
  1. inst_ok=0: adr <= adr+1 (NOP).
  2. inst_sr==RTN_OP: adr <= rtn_adr.
  3. inst_sr==KEY_OP: adr <= {2'b00, kcode}; brh_taken=1.
  4. inst_sr[1:0]==2'b01 (jsb): rtn_adr <= adr+1; adr <= inst_sr[9:2]; brh_taken=1.
  5. inst_sr[1:0]==2'b11 (branch): if carry_acc==0, adr <= inst_sr[9:2] and brh_taken=1; else adr <= adr+1.
  6. Otherwise: adr <= adr+1.
- The bit count is cleared at T55.
- Arithmetic:
  - adr+1 is modulo 2^ADR_W; 8'hFF wraps to 8'h00.
  - rtn_adr of a jsb at 8'hFF is 8'h00.
- Return stack is one level deep. A nested jsb overwrites rtn_adr; return does not modify rtn_adr.
- brh_taken is registered, high for exactly the cycle following the T55 edge, and 0 otherwise.
- sys_cnt values 56..63 are illegal:
  - no capture, no carry accumulation, no address update;
  - ia=0.
- Simultaneous events:
  - A carry at T55 itself is ignored; it is neither accumulated nor used.
  - A kcode change during T55 is sampled at that edge.
- Reset mid-word: all state clears immediately. The first T55 after release performs a NOP increment to adr=1, unless a full capture window occurred after release.

Test Plan:
- Reset, then run 3 words with is=0 (inst 0x000, class 00) -> adr goes 0→1→2→3; ia in T19..T26 of word 2 shows LSB-first 0x02 (bits 0,1,0,0,0,0,0,0); brh_taken never asserted.
- adr=0x10, serial inst 0x0A5 (jsb, target 0x29) -> after T55, adr=0x29, rtn_adr=0x11, brh_taken high 1 cycle; next word feed RTN_OP 0x030 -> adr=0x11, rtn_adr stays 0x11.
- Branch inst 0x0C3 (target 0x30) with carry pulsed at T12 of the same word -> adr=old+1, brh_taken=0. Repeat with carry only at T55 -> adr=0x30, brh_taken=1.
- kcode=6'h2A, inst KEY_OP 0x0D0 -> adr=0x2A, brh_taken=1. Also jsb at adr=0xFF -> rtn_adr=0x00; NOP at 0xFF -> adr=0x00.
- Assert pon at T50 with adr=0x55, release at T51 -> adr=0 immediately; at T55 inst_ok=0, so adr=1 regardless of is content; ia=0 throughout reset.
- Force sys_cnt=60 for 4 cycles mid-run -> adr, rtn_adr, carry_acc unchanged; ia=0.
